// File: rtl/t_seq_if.sv
// t_seq_if -- handshake bundle between the test scheduler and its environment.
//
// Signals:
//   go          run request (environment -> scheduler)
//   skip_mask   per-test skip bits (environment -> scheduler)
//   test_done   per-test done strobes (sub-tests -> scheduler)
//   test_pass   per-test pass flags, valid with test_done (sub-tests -> scheduler)
//   test_start  one-hot start pulse (scheduler -> sub-tests)
//   cur_idx     index of the test being run
//   busy        run in progress
//   result      per-test pass bits
//   timed_out   per-test timeout flags
//   finished    run complete
//   passed      aggregate pass, valid while finished
//
// Modports: master = environment/sub-test side, slave = scheduler side.
interface t_seq_if #(
  parameter int NTESTS = 21,
  parameter int IW     = $clog2(NTESTS)
);
  logic              go;
  logic [NTESTS-1:0] skip_mask;
  logic [NTESTS-1:0] test_done;
  logic [NTESTS-1:0] test_pass;
  logic [NTESTS-1:0] test_start;
  logic [IW-1:0]     cur_idx;
  logic              busy;
  logic [NTESTS-1:0] result;
  logic [NTESTS-1:0] timed_out;
  logic              finished;
  logic              passed;

  modport master (
    output go, skip_mask, test_done, test_pass,
    input  test_start, cur_idx, busy, result, timed_out, finished, passed
  );

  modport slave (
    input  go, skip_mask, test_done, test_pass,
    output test_start, cur_idx, busy, result, timed_out, finished, passed
  );
endinterface

// File: rtl/t_seq.sv
// t_seq -- sequential test scheduler.
//
// Runs NTESTS sub-tests one at a time in index order. Each non-skipped test
// gets a one-cycle start pulse and then up to TIMEOUT cycles to return its
// done/pass response; skipped tests score as pass. Per-test result and
// timeout bits are collected and an aggregate pass is presented once the
// run is finished.
//
// Ports:
//   clk      sole clock, rising edge
//   reset_l  synchronous active-low reset
//   bus      t_seq_if.slave (go, skip_mask, test_done, test_pass in;
//            test_start, cur_idx, busy, result, timed_out, finished,
//            passed out)
//
// All outputs come from state registers only; there is no combinational
// path from any input to any output.
module t_seq #(
  parameter int NTESTS  = 21,
  parameter int TIMEOUT = 1000,
  parameter int IW      = $clog2(NTESTS),
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input logic   clk,
  input logic   reset_l,
  t_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state_r,     state_nxt_s;
  logic [IW-1:0]     cur_idx_r,   cur_idx_nxt_s;
  logic [TW-1:0]     timer_r,     timer_nxt_s;
  logic [NTESTS-1:0] result_r,    result_nxt_s;
  logic [NTESTS-1:0] timed_out_r, timed_out_nxt_s;
  logic [NTESTS-1:0] test_start_s;
  logic              advance_s;
  logic              last_s;

  assign last_s = (cur_idx_r == IW'(NTESTS - 1));

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_r     <= IDLE;
      cur_idx_r   <= '0;
      timer_r     <= '0;
      result_r    <= '0;
      timed_out_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      cur_idx_r   <= cur_idx_nxt_s;
      timer_r     <= timer_nxt_s;
      result_r    <= result_nxt_s;
      timed_out_r <= timed_out_nxt_s;
    end
  end

  // Next-state logic; a test's completion (skip, done or timeout) funnels
  // into a shared advance step that moves to the next index or to DONE.
  always_comb begin
    state_nxt_s     = state_r;
    cur_idx_nxt_s   = cur_idx_r;
    timer_nxt_s     = timer_r;
    result_nxt_s    = result_r;
    timed_out_nxt_s = timed_out_r;
    advance_s       = 1'b0;

    case (state_r)
      IDLE, DONE: begin
        if (bus.go) begin
          result_nxt_s    = '0;
          timed_out_nxt_s = '0;
          cur_idx_nxt_s   = '0;
          state_nxt_s     = SELECT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      SELECT: begin
        if (bus.skip_mask[cur_idx_r]) begin
          result_nxt_s[cur_idx_r] = 1'b1;
          advance_s               = 1'b1;
        end else begin
          state_nxt_s = START;
        end
      end
      START: begin
        timer_nxt_s = '0;
        state_nxt_s = WAIT;
      end
      WAIT: begin
        // done is checked first so it wins over a coincident timeout
        if (bus.test_done[cur_idx_r]) begin
          result_nxt_s[cur_idx_r] = bus.test_pass[cur_idx_r];
          advance_s               = 1'b1;
        end else if (timer_r == TW'(TIMEOUT - 1)) begin
          result_nxt_s[cur_idx_r]    = 1'b0;
          timed_out_nxt_s[cur_idx_r] = 1'b1;
          advance_s                  = 1'b1;
        end else begin
          timer_nxt_s = timer_r + TW'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    if (advance_s) begin
      if (last_s) begin
        state_nxt_s = DONE;
      end else begin
        cur_idx_nxt_s = cur_idx_r + IW'(1);
        state_nxt_s   = SELECT;
      end
    end else begin
      advance_s = 1'b0;
    end
  end

  // Start pulse decoded from the START state and the registered index.
  always_comb begin
    test_start_s = '0;
    if (state_r == START) begin
      test_start_s[cur_idx_r] = 1'b1;
    end else begin
      test_start_s = '0;
    end
  end

  assign bus.test_start = test_start_s;
  assign bus.cur_idx    = cur_idx_r;
  assign bus.busy       = (state_r == SELECT) || (state_r == START) || (state_r == WAIT);
  assign bus.result     = result_r;
  assign bus.timed_out  = timed_out_r;
  assign bus.finished   = (state_r == DONE);
  assign bus.passed     = (state_r == DONE) && (&result_r);

endmodule

// File: tb/tb_t_seq.sv
// tb_t_seq -- self-checking bench for t_seq with NTESTS=4, TIMEOUT=8.
// A table of run configurations (skip mask, per-test response delay and
// pass flag) is applied with a small responder; expected results, cycle
// counts and start masks are hand-computed in the table. Reset, restart
// from DONE and reset mid-run are hand-written sequences.
module tb_t_seq;
  localparam int NT = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset_l;
  int   n_checks = 0;
  int   n_miss   = 0;

  always #5 clk = ~clk;

  t_seq_if #(.NTESTS(NT)) bus ();

  t_seq #(.NTESTS(NT), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  // k: WAIT cycle (1-based) in which done is asserted; 0 = never.
  typedef struct packed {
    logic [3:0]      skip;
    logic [3:0][3:0] k;
    logic [3:0]      pass;
    logic            stray;
    logic [3:0]      exp_res;
    logic [3:0]      exp_to;
    logic            exp_passed;
    logic [7:0]      exp_cyc;
    logic [3:0]      exp_starts;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input logic [3:0] skip, input logic [3:0] k0,
                              input logic [3:0] k1, input logic [3:0] k2,
                              input logic [3:0] k3, input logic [3:0] pass,
                              input logic stray, input logic [3:0] res,
                              input logic [3:0] tout, input logic psd,
                              input logic [7:0] cyc, input logic [3:0] starts);
    vec_t v;
    v.skip = skip; v.k = {k3, k2, k1, k0}; v.pass = pass; v.stray = stray;
    v.exp_res = res; v.exp_to = tout; v.exp_passed = psd;
    v.exp_cyc = cyc; v.exp_starts = starts;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.test_start, bus.cur_idx, bus.busy, bus.result,
            bus.timed_out, bus.finished, bus.passed};
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int         cyc = 0;
    int         cur = 0;
    int         w = 0;
    bit         active = 0;
    bit         prev = 0;
    bit         err = 0;
    bit         got = 0;
    logic [3:0] seen = '0;
    logic [3:0] cur_oh;
    bus.skip_mask = v.skip;
    bus.test_pass = v.pass;
    bus.test_done = '0;
    bus.go = 1'b1;
    @(posedge clk); #1;
    if (!v.stray) bus.go = 1'b0;
    while (cyc < 200 && !got) begin
      bus.test_done = '0;
      bus.test_pass = v.pass;
      if (bus.test_start != '0) begin
        if ($countones(bus.test_start) != 1 || prev) err = 1;
        seen |= bus.test_start;
        for (int i = 0; i < NT; i++) if (bus.test_start[i]) cur = i;
        active = 1; w = 0; prev = 1;
        if (v.stray) begin
          // done with a failing pass during START must be ignored
          bus.test_done = bus.test_start;
          bus.test_pass = v.pass & ~bus.test_start;
        end
      end else begin
        prev = 0;
        if (active && bus.busy && int'(bus.cur_idx) == cur) begin
          w++;
          if (w == int'(v.k[cur])) bus.test_done[cur] = 1'b1;
        end
      end
      if (v.stray) begin
        cur_oh = active ? (4'b0001 << cur) : 4'b0000;
        bus.test_done = bus.test_done | ~cur_oh;
      end
      @(posedge clk); #1;
      cyc++;
      if (bus.finished) got = 1;
    end
    bus.go = 1'b0;
    bus.test_done = '0;
    check($sformatf("v%0d finished", id), 32'(got), 32'd1);
    check($sformatf("v%0d cycles", id), 32'(cyc), 32'(v.exp_cyc));
    check($sformatf("v%0d result", id), 32'(bus.result), 32'(v.exp_res));
    check($sformatf("v%0d timed_out", id), 32'(bus.timed_out), 32'(v.exp_to));
    check($sformatf("v%0d passed", id), 32'(bus.passed), 32'(v.exp_passed));
    check($sformatf("v%0d starts", id), 32'(seen), 32'(v.exp_starts));
    check($sformatf("v%0d start_shape", id), 32'(err), 32'd0);
    check($sformatf("v%0d idx_busy", id), {30'd0, bus.cur_idx}, 32'd3);
    check($sformatf("v%0d busy", id), 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bit   bad;
    int   n;
    //                skip     k0 k1 k2 k3   pass     st  res      to       p  cyc  starts
    vecs[0] = mk(4'b0000, 4'd1, 4'd1, 4'd1, 4'd1, 4'b1111, 1'b0, 4'b1111, 4'b0000, 1'b1, 8'd12, 4'b1111);
    vecs[1] = mk(4'b0000, 4'd1, 4'd1, 4'd0, 4'd1, 4'b1101, 1'b0, 4'b1001, 4'b0100, 1'b0, 8'd19, 4'b1111);
    vecs[2] = mk(4'b1010, 4'd1, 4'd1, 4'd1, 4'd1, 4'b1111, 1'b0, 4'b1111, 4'b0000, 1'b1, 8'd8,  4'b0101);
    vecs[3] = mk(4'b0000, 4'd1, 4'd1, 4'd8, 4'd1, 4'b1011, 1'b0, 4'b1011, 4'b0000, 1'b0, 8'd19, 4'b1111);
    vecs[4] = mk(4'b0000, 4'd2, 4'd1, 4'd3, 4'd1, 4'b1111, 1'b1, 4'b1111, 4'b0000, 1'b1, 8'd15, 4'b1111);
    vecs[5] = mk(4'b1111, 4'd1, 4'd1, 4'd1, 4'd1, 4'b0000, 1'b0, 4'b1111, 4'b0000, 1'b1, 8'd4,  4'b0000);
    vecs[6] = mk(4'b0000, 4'd9, 4'd1, 4'd1, 4'd3, 4'b0111, 1'b0, 4'b0110, 4'b0001, 1'b0, 8'd21, 4'b1111);

    // reset and idle
    reset_l = 1'b0; bus.go = 1'b0; bus.skip_mask = '0;
    bus.test_done = '0; bus.test_pass = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", all_outs(), 32'd0);
    reset_l = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (all_outs() != 32'd0) bad = 1;
    end
    check("idle outputs", 32'(bad), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // restart from DONE: clear on next edge, start pulse one cycle later
    bus.skip_mask = '0;
    bus.go = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
    check("restart clear", {bus.result, bus.timed_out, bus.finished, bus.busy, bus.test_start},
          {4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000});
    @(posedge clk); #1;
    check("restart start0", {bus.test_start, 2'b00, bus.cur_idx}, {4'b0001, 2'b00, 2'd0});

    // reset in WAIT of test 2
    bus.test_done = 4'b0011; bus.test_pass = 4'b1111;
    n = 0;
    while (bus.test_start != 4'b0100 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("reach start2", 32'(bus.test_start), 32'h4);
    @(posedge clk); #1;
    check("in wait2", {bus.busy, bus.result}, {1'b1, 4'b0011});
    reset_l = 1'b0;
    @(posedge clk); #1;
    check("midrun reset", all_outs(), 32'd0);
    reset_l = 1'b1; bus.test_done = '0;
    bus.go = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
    check("rerun select", {bus.busy, bus.cur_idx, bus.test_start}, {1'b1, 2'd0, 4'b0000});
    @(posedge clk); #1;
    check("rerun start0", 32'(bus.test_start), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end
endmodule

// File: doc/t_seq.md
# t_seq

Test scheduler for the self-checking test top. It runs up to NTESTS sub-test modules one at a time, in index order, by pulsing each module's start and waiting for its done/pass response under a per-test timeout. It collects one result bit per test and presents an aggregate `passed`. It replaces the static AND of free-running `passed` bits, so sub-tests that share the clock domain never overlap.

## Interface
- NTESTS, 21: number of sub-test slots, at least 2.
- TIMEOUT, 1000: maximum WAIT cycles allowed per test, at least 2.
- IW, $clog2(NTESTS): index width.
- TW, $clog2(TIMEOUT+1): timer width.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset_l  in  1  reset, synchronous, active-low.
- go  in  1  start a run; sampled only in IDLE or DONE.
- skip_mask  in  NTESTS  bit i=1 means test i is not run and scores as pass; sampled per test in SELECT.
- test_done  in  NTESTS  done strobe from test i; only bit cur_idx is looked at, only in WAIT.
- test_pass  in  NTESTS  pass flag from test i; sampled with test_done.
- test_start  out  NTESTS  one-hot, one-cycle start pulse to test i.
- cur_idx  out  IW  index of the test being run.
- busy  out  1  high in SELECT, START, WAIT.
- result  out  NTESTS  per-test pass bits.
- timed_out  out  NTESTS  per-test timeout flags.
- finished  out  1  high in DONE.
- passed  out  1  equals &result while finished is high; 0 otherwise.

## Operation
- FSM states: IDLE, SELECT, START, WAIT, DONE. All outputs are registered or decoded from state only. No combinational input-to-output paths.
- Reset (reset_l=0 at an edge), from any state including mid-run:
  - state=IDLE.
  - cur_idx=0, timer=0.
  - result=0, timed_out=0.
  - test_start=0, busy=0, finished=0, passed=0.
- IDLE, go=1:
  - Clear result and timed_out.
  - Set cur_idx=0.
  - Go to SELECT.
- SELECT:
  - If skip_mask[cur_idx]=1: set result[cur_idx]=1, then advance.
  - Otherwise: go to START.
- START:
  - test_start[cur_idx]=1 for exactly this cycle.
  - timer=0.
  - Go to WAIT.
- WAIT, each cycle:
  - If test_done[cur_idx]=1: result[cur_idx]=test_pass[cur_idx], then advance.
  - Else if timer==TIMEOUT-1: result[cur_idx]=0, timed_out[cur_idx]=1, then advance.
  - Else: timer+1.
- Advance:
  - If cur_idx==NTESTS-1: go to DONE.
  - Otherwise: cur_idx+1, go to SELECT.
- DONE:
  - Hold result, timed_out, passed and cur_idx=NTESTS-1.
  - go=1: same action as go in IDLE (clear and restart).
- go while busy is ignored.
- test_done bits other than cur_idx, and test_done outside WAIT, are ignored.
- Timer never wraps. It saturates by construction because the timeout exits WAIT.

## Timing
- go sampled at edge E0, with state IDLE → SELECT at E0.
  - Non-skipped test 0: test_start[0] is high in the cycle after E1.
  - WAIT begins at E2.
- Per non-skipped test, from entering SELECT:
  - 1 cycle SELECT.
  - 1 cycle START.
  - k cycles WAIT, with k ≥ 1.
  - The earliest done is accepted in the first WAIT cycle (k=1).
- Per skipped test: 1 cycle.
- Timeout: test_done never asserted gives exactly TIMEOUT WAIT cycles (timer 0..TIMEOUT-1), with the result written at the last one.
- Simultaneous done and timeout in the same cycle: done wins, and timed_out stays 0.
- finished and passed rise in the first cycle in DONE, after the last test's result edge.
- Total run with no skips and all done at k=1: 3·NTESTS cycles from go to finished.

## Test plan
Parameters NTESTS=4, TIMEOUT=8 throughout.
- Reset / idle: hold reset_l=0 for 3 cycles, then release with go=0 for 10 cycles → all outputs 0, test_start never asserted.
- All pass, fastest:
  - Stimulus: go pulse; each test answers done=1, pass=1 in its first WAIT cycle.
  - Response: test_start pulses 0001, 0010, 0100, 1000, each 1 cycle and 3 cycles apart; finished at go+12; result=1111, passed=1.
- Fail and timeout:
  - Stimulus: test 1 returns pass=0; test 2 never asserts done.
  - Response: result=1001, timed_out=0100, passed=0; test 2 occupies exactly 8 WAIT cycles.
- Skip and boundary:
  - Stimulus: skip_mask=1010.
  - Response: test_start pulses only for 0 and 2; result=1111, passed=1.
  - Stimulus: done arrives on cycle 8 of WAIT together with the timeout condition.
  - Response: result bit taken from test_pass, timed_out bit 0.
- Robustness:
  - Stimulus: go asserted repeatedly while busy; stray test_done on non-current bits; done asserted during START.
  - Response: all of these are ignored, and the run completes unchanged.
  - Stimulus: reset_l=0 asserted in WAIT of test 2.
  - Response: next cycle all outputs 0 and state IDLE; a following go runs from test 0.
- Restart from DONE:
  - Stimulus: go pulsed while finished=1.
  - Response: result and timed_out clear on the next edge, and test_start[0] pulses one cycle later.
